irq_ctrl: RTL and testbench

Interrupt controller that sequences the RISC5 CPU's single `irq` input. It collects up to 16 device interrupt lines, such as the ms timer tick and the RS232/SPI/GPIO status lines. It latches and masks them, prioritises them, and drives one interrupt request with a claim / end-of-interrupt (EOI) handshake. It sits in the IO block as a four-word device at -96, -92, -88 and -84, selected by `adr[7:4] == 4'b1010`.

---
 rtl/irq_pkg.sv | 28 ++
 rtl/irq_prio_enc.sv | 27 ++
 rtl/irq_ctrl.sv | 157 +++++++++++++++
 tb/tb_irq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt controller.
//   - irq_state_t : controller state (IDLE / ACTIVE / SERVICE)
//   - REG_*       : register offsets selected by addr (adr[3:2])
//   - VEC_*       : bit positions of the fields in the VEC register
//   - MAX_IRQ     : largest supported number of source lines
//   - IDX_W       : width of a source index (enough for 0..MAX_IRQ-1)
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_EN   = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_VEC  = 2'd3;

    localparam int VEC_VALID   = 31;
    localparam int VEC_INSVC   = 30;
    localparam int VEC_CUR_LSB = 8;
    localparam int VEC_TOP_LSB = 0;

    localparam int MAX_IRQ = 16;
    localparam int IDX_W   = 5;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first priority encoder.
// Ports:
//   req   in  num_irq  request vector (enabled & pending)
//   valid out 1        any request present
//   idx   out IDX_W    index of the lowest set bit; 0 when nothing is set
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int num_irq = 8
) (
    input  logic [num_irq-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = num_irq - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller driving the CPU's single irq input.
// Latches up to num_irq source lines (edge or level per source), masks
// them, picks the lowest-numbered enabled pending source and runs a
// claim / end-of-interrupt handshake with the CPU.
// Ports:
//   clk      in  1        system clock
//   rst      in  1        synchronous active-high reset
//   stb      in  1        device select
//   we       in  1        write strobe (read when low)
//   addr     in  2        register select: PEND / EN / MODE / VEC
//   data_in  in  32       write data
//   data_out out 32       read data, combinational, 0 when stb is low
//   ack      out 1        equal to stb (no wait states)
//   irq_in   in  num_irq  source lines, clk-synchronous, active-high
//   irq_out  out 1        registered interrupt request
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int num_irq = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stb,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               ack,
    input  logic [num_irq-1:0] irq_in,
    output logic               irq_out
);

    logic [num_irq-1:0] pend, en, mode, prev;
    logic [num_irq-1:0] pend_next, edge_set, clr, mode_chg, wdata, active;
    logic [IDX_W-1:0]   cur_idx, top_idx;
    logic               valid, wr, vec_rd, vec_rd_d, claim, eoi, irq_d;
    logic               unused_wdata_hi;
    irq_state_t         st, st_next;

    assign ack             = stb;
    assign wdata           = data_in[num_irq-1:0];
    assign unused_wdata_hi = ^data_in[31:num_irq];
    assign active          = pend & en;

    irq_prio_enc #(.num_irq(num_irq)) u_prio (
        .req   (active),
        .valid (valid),
        .idx   (top_idx)
    );

    // A claim fires only on the first cycle of a VEC read, so a read held
    // across several cycles claims once.
    assign wr     = stb & we;
    assign vec_rd = stb & ~we & (addr == REG_VEC);
    assign claim  = vec_rd & ~vec_rd_d & valid & (st != SERVICE);
    assign eoi    = wr & (addr == REG_VEC) & (st == SERVICE);

    // Edge sources: a new edge beats any clear in the same cycle.
    // Level sources simply track the line. A MODE change drops the bit.
    always_comb begin
        edge_set = irq_in & ~prev;
        clr      = '0;
        mode_chg = '0;
        if (wr && addr == REG_PEND) begin
            clr = wdata;
        end
        for (int i = 0; i < num_irq; i++) begin
            if (claim && top_idx == IDX_W'(i)) begin
                clr[i] = 1'b1;
            end
        end
        if (wr && addr == REG_MODE) begin
            mode_chg = wdata ^ mode;
        end
        pend_next = ((mode & (edge_set | (pend & ~clr))) | (~mode & irq_in))
                    & ~mode_chg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            pend     <= '0;
            en       <= '0;
            mode     <= '0;
            cur_idx  <= '0;
            vec_rd_d <= 1'b0;
        end else begin
            prev     <= irq_in;
            pend     <= pend_next;
            vec_rd_d <= vec_rd;
            if (wr && addr == REG_EN) begin
                en <= wdata;
            end
            if (wr && addr == REG_MODE) begin
                mode <= wdata;
            end
            if (claim) begin
                cur_idx <= top_idx;
            end
        end
    end

    // State register; irq_out is registered alongside it so it always
    // equals (st == ACTIVE).
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            irq_out <= 1'b0;
        end else begin
            st      <= st_next;
            irq_out <= irq_d;
        end
    end

    // A claim from IDLE covers a read racing the IDLE->ACTIVE step.
    // SERVICE always returns through IDLE so valid is re-evaluated.
    always_comb begin
        st_next = st;
        case (st)
            IDLE: begin
                if (claim)      st_next = SERVICE;
                else if (valid) st_next = ACTIVE;
            end
            ACTIVE: begin
                if (claim)       st_next = SERVICE;
                else if (!valid) st_next = IDLE;
            end
            SERVICE: begin
                if (eoi) st_next = IDLE;
            end
            default: st_next = IDLE;
        endcase
    end

    always_comb begin
        irq_d = (st_next == ACTIVE);
    end

    always_comb begin
        data_out = '0;
        if (stb) begin
            case (addr)
                REG_PEND: data_out = 32'(pend);
                REG_EN:   data_out = 32'(en);
                REG_MODE: data_out = 32'(mode);
                REG_VEC: begin
                    data_out[VEC_VALID]               = valid;
                    data_out[VEC_INSVC]               = (st == SERVICE);
                    data_out[VEC_CUR_LSB +: IDX_W]    = cur_idx;
                    data_out[VEC_TOP_LSB +: IDX_W]    = top_idx;
                end
                default: data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: self-checking bench for irq_ctrl (num_irq = 8).
// Register reads push their expected value onto a scoreboard queue when
// the read is driven and pop it when data_out is sampled mid-cycle.
module tb_irq_ctrl;

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_EN   = 2'd1;
    localparam logic [1:0] A_MODE = 2'd2;
    localparam logic [1:0] A_VEC  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic [7:0]  irq_in;
    logic        irq_out;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_checks = 0;
    int        n_fails  = 0;

    irq_ctrl #(.num_irq(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .irq_in   (irq_in),
        .irq_out  (irq_out)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] lines);
        irq_in = lines;
        tick();
    endtask

    task automatic check_irq(input string tag, input logic expected);
        checkOutput(tag, 32'(irq_out), 32'(expected));
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        stb     = 1'b1;
        we      = 1'b1;
        addr    = a;
        data_in = d;
        tick();
        stb     = 1'b0;
        we      = 1'b0;
        data_in = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        stb  = 1'b1;
        we   = 1'b0;
        addr = a;
        #2;
        e = sb_q.pop_front();
        checkOutput(e.tag, data_out, e.exp);
        checkOutput({e.tag, "_ack"}, 32'(ack), 32'd1);
        tick();
        stb = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        stb     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        data_in = '0;
        irq_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkOutput("dout_idle", data_out, 32'h0);
        check_irq("irq_reset", 1'b0);
        bus_read(A_PEND, "pend_reset", 32'h0);
        bus_read(A_EN,   "en_reset",   32'h0);
        bus_read(A_MODE, "mode_reset", 32'h0);
        bus_read(A_VEC,  "vec_reset",  32'h0);
        applyStimulus(8'h04);
        bus_read(A_PEND, "pend_masked", 32'h04);
        check_irq("irq_masked", 1'b0);
        applyStimulus(8'h00);

        // Edge path
        bus_write(A_EN,   32'h05);
        bus_write(A_MODE, 32'h05);
        applyStimulus(8'h04);
        check_irq("edge_lat_k", 1'b0);
        applyStimulus(8'h00);
        check_irq("edge_lat_k1", 1'b1);
        bus_read(A_VEC, "edge_claim", 32'h8000_0002);
        check_irq("edge_after_claim", 1'b0);
        tick();
        bus_read(A_VEC, "edge_insvc", 32'h4000_0200);
        bus_write(A_VEC, 32'h0);
        check_irq("edge_eoi", 1'b0);
        tick();
        check_irq("edge_eoi_idle", 1'b0);

        // Priority
        applyStimulus(8'h05);
        applyStimulus(8'h00);
        check_irq("prio_req", 1'b1);
        bus_read(A_VEC, "prio_claim0", 32'h8000_0200);
        check_irq("prio_claim0_irq", 1'b0);
        tick();
        bus_write(A_VEC, 32'h0);
        check_irq("prio_eoi_irq", 1'b0);
        tick();
        check_irq("prio_reassert", 1'b1);
        bus_read(A_VEC, "prio_claim2", 32'h8000_0002);
        tick();
        bus_write(A_VEC, 32'h0);
        tick();

        // Level mode
        bus_write(A_MODE, 32'h00);
        bus_write(A_EN,   32'h02);
        applyStimulus(8'h02);
        tick();
        check_irq("lvl_req", 1'b1);
        bus_read(A_VEC, "lvl_claim1", 32'h8000_0201);
        check_irq("lvl_claim1_irq", 1'b0);
        tick();
        bus_write(A_VEC, 32'h0);
        check_irq("lvl_eoi1", 1'b0);
        tick();
        check_irq("lvl_reassert", 1'b1);
        bus_read(A_VEC, "lvl_claim2", 32'h8000_0101);
        applyStimulus(8'h00);
        bus_write(A_VEC, 32'h0);
        check_irq("lvl_eoi2", 1'b0);
        tick();
        check_irq("lvl_quiet", 1'b0);

        // Collisions
        bus_write(A_EN,   32'h00);
        bus_write(A_MODE, 32'h01);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        irq_in = 8'h01;
        bus_write(A_PEND, 32'h01);
        bus_read(A_PEND, "w1c_set_wins", 32'h01);
        irq_in = 8'h03;
        bus_write(A_PEND, 32'h03);
        bus_read(A_PEND, "w1c_edge_only", 32'h02);
        applyStimulus(8'h00);
        bus_write(A_VEC, 32'h0);
        bus_read(A_VEC, "eoi_in_idle", 32'h0000_0100);
        check_irq("eoi_in_idle_irq", 1'b0);

        // Mask while ACTIVE
        bus_write(A_EN, 32'h01);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        check_irq("mask_active", 1'b1);
        bus_write(A_EN, 32'h00);
        check_irq("mask_edge1", 1'b1);
        tick();
        check_irq("mask_edge2", 1'b0);

        // EN change during SERVICE, then reset
        bus_write(A_EN, 32'h01);
        tick();
        check_irq("svc_req", 1'b1);
        bus_read(A_VEC, "svc_claim", 32'h8000_0100);
        bus_write(A_EN, 32'h00);
        check_irq("svc_en_clear", 1'b0);
        bus_read(A_VEC, "svc_hold", 32'h4000_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_irq("rst_irq", 1'b0);
        bus_read(A_PEND, "rst_pend", 32'h0);
        bus_read(A_EN,   "rst_en",   32'h0);
        bus_read(A_MODE, "rst_mode", 32'h0);
        bus_read(A_VEC,  "rst_vec",  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
